// File: rtl/pe_mac_sequencer.sv
// Issue/hazard/credit sequencer for a single pe_unit MAC pipeline.
// Rounded results are collected in a small FIFO and drained over a valid/ready port.
module pe_mac_sequencer #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int RES_DEPTH      = 4,
  localparam int W = para_int_bits + para_frac_bits
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pause,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [2:0]   op_idx,
  input  logic         op_last,
  output logic [W-1:0] pe_data_in_1,
  output logic [W-1:0] pe_data_in_2,
  output logic [3:0]   pe_add_number,
  output logic         pe_rounder_en,
  output logic         pe_keep,
  input  logic [W-1:0] pe_data_out,
  input  logic         pe_rounder_valid,
  input  logic [3:0]   pe_round_number,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [2:0]   res_idx,
  output logic         busy
);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);

  logic          hz_valid_q, hz_valid_d;
  logic [2:0]    hz_idx_q, hz_idx_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          cap_valid_q;
  logic [2:0]    cap_idx_q;
  logic [W+2:0]  mem_q [RES_DEPTH];

  logic no_credit, hazard, issue, round_issue, push, pop;
  logic unused_rn;

  assign unused_rn = pe_round_number[3];

  // A round needs a guaranteed FIFO slot before it may be issued.
  assign no_credit   = (count_q + inflight_q) >= DEPTH_C;
  assign hazard      = hz_valid_q && (op_idx == hz_idx_q);
  assign op_ready    = rst_n && !pause && !hazard && !(op_last && no_credit);
  assign issue       = op_valid && op_ready;
  assign round_issue = issue && op_last;

  assign res_valid            = (count_q != '0);
  assign {res_idx, res_data}  = mem_q[rd_ptr_q];
  assign pop                  = res_valid && res_ready;
  assign push                 = cap_valid_q && ((count_q != DEPTH_C) || pop);
  assign busy                 = (inflight_q != '0) || res_valid;

  // Freezing is only allowed once no round is draining through the pe pipeline.
  always_comb begin
    pe_data_in_1  = '0;
    pe_data_in_2  = '0;
    pe_add_number = '0;
    pe_rounder_en = 1'b0;
    pe_keep       = 1'b0;
    if (issue) begin
      pe_data_in_1  = op_a;
      pe_data_in_2  = op_b;
      pe_add_number = {1'b0, op_idx};
      pe_rounder_en = op_last;
    end else if (rst_n && pause && (inflight_q == '0)) begin
      pe_keep = 1'b1;
    end
  end

  always_comb begin
    hz_valid_d = round_issue;
    hz_idx_d   = op_idx;

    inflight_d = inflight_q;
    if (round_issue && !push)      inflight_d = inflight_q + 1'b1;
    else if (!round_issue && push) inflight_d = inflight_q - 1'b1;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hz_valid_q  <= 1'b0;
      hz_idx_q    <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
    end else begin
      hz_valid_q  <= hz_valid_d;
      hz_idx_q    <= hz_idx_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cap_valid_q <= pe_rounder_valid;
      cap_idx_q   <= pe_round_number[2:0];
    end
  end

  // pe_data_out trails rounder_valid by one cycle, so it pairs with the captured index.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cap_idx_q, pe_data_out};
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Bench for pe_mac_sequencer: behavioural pe_unit stand-in, directed scenarios and
// randomized traffic checked against a queue-based model of results and handshakes.
module tb_pe_mac_sequencer;
  localparam int W     = 16;
  localparam int FB    = 9;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pause = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_last = 1'b0;
  logic         res_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   op_idx = '0;
  logic         op_ready;
  logic [W-1:0] pe_data_in_1, pe_data_in_2, pe_data_out;
  logic [3:0]   pe_add_number, pe_round_number;
  logic         pe_rounder_en, pe_keep, pe_rounder_valid;
  logic         res_valid, busy;
  logic [W-1:0] res_data;
  logic [2:0]   res_idx;

  pe_mac_sequencer #(.para_int_bits(7), .para_frac_bits(FB), .RES_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_idx(op_idx), .op_last(op_last),
    .pe_data_in_1(pe_data_in_1), .pe_data_in_2(pe_data_in_2),
    .pe_add_number(pe_add_number), .pe_rounder_en(pe_rounder_en), .pe_keep(pe_keep),
    .pe_data_out(pe_data_out), .pe_rounder_valid(pe_rounder_valid),
    .pe_round_number(pe_round_number),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[W+FB-1:FB];
  endfunction

  // pe_unit stand-in: accumulate, round+clear, rounder_valid 2 cycles later, data one cycle after that.
  logic [W-1:0] pe_acc [8];
  logic [W-1:0] pe_sum;
  logic         r1_v, r2_v;
  logic [2:0]   r1_i, r2_i;
  logic [W-1:0] r1_d, r2_d, r3_d;

  always @(posedge clk) begin
    if (!rst_n) begin
      r1_v <= 1'b0; r2_v <= 1'b0; r1_i <= '0; r2_i <= '0;
      r1_d <= '0; r2_d <= '0; r3_d <= '0;
      for (int i = 0; i < 8; i++) pe_acc[i] <= '0;
    end else if (!pe_keep) begin
      pe_sum = pe_acc[pe_add_number[2:0]] + qmul(pe_data_in_1, pe_data_in_2);
      pe_acc[pe_add_number[2:0]] <= pe_rounder_en ? '0 : pe_sum;
      r1_v <= pe_rounder_en; r1_i <= pe_add_number[2:0]; r1_d <= pe_sum;
      r2_v <= r1_v; r2_i <= r1_i; r2_d <= r1_d;
      r3_d <= r2_d;
    end
  end

  assign pe_rounder_valid = r2_v;
  assign pe_round_number  = {1'b0, r2_i};
  assign pe_data_out      = r3_d;

  // Reference: each accepted last creates one expected result, visible 4 cycles later,
  // and holds a FIFO credit until it is popped.
  typedef struct packed {
    logic [2:0]   idx;
    logic [W-1:0] data;
    int           rdy;
  } res_t;

  res_t         exp_q[$];
  logic [W-1:0] m_acc [8];
  logic [W-1:0] m_sum;
  logic         hz_v_m = 1'b0;
  logic [2:0]   hz_i_m = '0;
  logic         prev_rst_low = 1'b0;
  logic         exp_ready, exp_keep, exp_rv, acc_m, inflight_m;
  int           cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_op_ready", op_ready, 0);
      chk("rst_keep", pe_keep, 0);
      chk("rst_rounder_en", pe_rounder_en, 0);
      if (prev_rst_low) begin
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
      end
      exp_q.delete();
      for (int i = 0; i < 8; i++) m_acc[i] = '0;
      hz_v_m = 1'b0;
      prev_rst_low = 1'b1;
    end else begin
      prev_rst_low = 1'b0;
      inflight_m = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].rdy > cyc) inflight_m = 1'b1;
      exp_ready = !pause && !(hz_v_m && op_idx == hz_i_m) && !(op_last && exp_q.size() >= DEPTH);
      exp_keep  = pause && !inflight_m;
      acc_m     = op_valid && exp_ready;
      exp_rv    = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);

      chk("op_ready", op_ready, exp_ready);
      chk("pe_keep", pe_keep, exp_keep);
      chk("res_valid", res_valid, exp_rv);
      chk("busy", busy, exp_q.size() > 0);
      chk("pe_rounder_en", pe_rounder_en, acc_m && op_last);
      chk("pe_add_number", pe_add_number, acc_m ? {1'b0, op_idx} : 4'd0);
      chk("pe_data_in_1", pe_data_in_1, acc_m ? op_a : '0);
      chk("pe_data_in_2", pe_data_in_2, acc_m ? op_b : '0);

      if (exp_rv && res_ready) begin
        chk("res_idx", res_idx, exp_q[0].idx);
        chk("res_data", res_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end

      hz_v_m = acc_m && op_last;
      hz_i_m = op_idx;
      if (acc_m) begin
        m_sum = m_acc[op_idx] + qmul(op_a, op_b);
        if (op_last) begin
          exp_q.push_back('{idx: op_idx, data: m_sum, rdy: cyc + 4});
          m_acc[op_idx] = '0;
        end else begin
          m_acc[op_idx] = m_sum;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] idx,
                      input logic last, input int budget, output logic ok);
    op_a = a; op_b = b; op_idx = idx; op_last = last; op_valid = 1'b1; ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      ok = op_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic ok;
  int   lat;

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    res_ready = 1'b1;

    // T1: 1.0*2.0 + 0.5*4.0 on idx3 -> 4.0, visible 4 cycles after the last
    send(16'h0200, 16'h0400, 3'd3, 1'b0, 20, ok); chk("t1_send0", ok, 1);
    send(16'h0100, 16'h0800, 3'd3, 1'b1, 20, ok); chk("t1_send1", ok, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      lat = k;
      if (res_valid) break;
    end
    chk("t1_latency", lat, 4);
    chk("t1_data", res_data, 16'h0800);
    chk("t1_idx", res_idx, 3);
    idle(6);

    // T2: same-index op right after a last is held for one cycle
    send(16'h0200, 16'h0200, 3'd1, 1'b1, 20, ok); chk("t2_last", ok, 1);
    op_a = 16'h0200; op_b = 16'h0600; op_idx = 3'd1; op_last = 1'b0; op_valid = 1'b1;
    @(negedge clk);
    chk("t2_hazard_ready", op_ready, 0);
    chk("t2_bubble_add", pe_add_number, 0);
    @(posedge clk); #1;
    send(16'h0200, 16'h0600, 3'd1, 1'b0, 20, ok); chk("t2_after_hazard", ok, 1);
    send(16'h0200, 16'h0200, 3'd1, 1'b1, 20, ok); chk("t2_last2", ok, 1);
    idle(10);

    // T3: credits stop the fifth outstanding round while the consumer stalls
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(16'h0200, 16'(i * 256 + 256), 3'(i), 1'b1, 20, ok);
      chk("t3_accept", ok, 1);
    end
    send(16'h0200, 16'h0200, 3'd4, 1'b1, 8, ok);
    chk("t3_fifth_blocked", ok, 0);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_drain_valid", res_valid, 1);
      chk("t3_order", res_idx, i);
      @(posedge clk); #1;
    end
    idle(6);

    // T4: pause one cycle after a last -> three bubbles, then freeze
    send(16'h0300, 16'h0200, 3'd5, 1'b1, 20, ok); chk("t4_last", ok, 1);
    pause = 1'b1;
    op_a = 16'h0100; op_b = 16'h0100; op_idx = 3'd6; op_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t4_keep", pe_keep, k >= 3);
      chk("t4_no_accept", op_ready, 0);
      @(posedge clk); #1;
    end
    pause = 1'b0; op_valid = 1'b0;
    idle(8);

    // T5: push into a busy FIFO while it drains
    res_ready = 1'b0;
    for (int i = 2; i < 5; i++) begin
      send(16'h0100, 16'(i * 512), 3'(i), 1'b1, 20, ok);
      chk("t5_fill", ok, 1);
    end
    idle(6);
    res_ready = 1'b1;
    send(16'h0400, 16'h0200, 3'd5, 1'b1, 20, ok); chk("t5_push_during_pop", ok, 1);
    idle(10);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      op_valid  = ($urandom_range(0, 3) != 0);
      op_a      = W'($urandom_range(0, 2047)) - 16'd1024;
      op_b      = W'($urandom_range(0, 2047)) - 16'd1024;
      op_idx    = 3'($urandom_range(0, 7));
      op_last   = ($urandom_range(0, 2) == 0);
      pause     = ($urandom_range(0, 11) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op_last = 1'b0; pause = 1'b0; res_ready = 1'b1;
    idle(10);

    // T6: reset with two rounds in flight and the FIFO holding a result
    res_ready = 1'b0;
    send(16'h0200, 16'h0200, 3'd0, 1'b1, 20, ok); chk("t6_first", ok, 1);
    idle(6);
    send(16'h0200, 16'h0400, 3'd1, 1'b1, 20, ok); chk("t6_inflight1", ok, 1);
    send(16'h0200, 16'h0600, 3'd2, 1'b1, 20, ok); chk("t6_inflight2", ok, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t6_no_stale", res_valid, 0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
